// File: rtl/conv_acc_stream.sv
// Multi-channel convolution accumulator: serial MAC per output pixel, bias/ReLU/saturate
// into a local frame buffer, then streams the frame out over valid/ready.
module conv_acc_stream #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 16,
    parameter int KERNEL_LEN = 4,
    parameter int CHANNELS   = 1,
    parameter int RESULT_W   = 3,
    parameter int RESULT_H   = 3,
    parameter int RELU_EN    = 0
) (
    input  logic                     clk_en,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] img_cal,
    input  logic signed [DATA_W-1:0] wei_cal,
    input  logic signed [OUT_W-1:0]  bias,
    output logic                     rlt_valid,
    input  logic                     rlt_ready,
    output logic [OUT_W-1:0]         rlt_data,
    output logic                     rlt_last,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     sat_flag
);
    localparam int KC = KERNEL_LEN * CHANNELS;
    localparam int N  = RESULT_W * RESULT_H;
    localparam int MW = (KC > 1) ? $clog2(KC) : 1;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [MW-1:0] MAC_LAST = MW'(KC - 1);
    localparam logic [AW-1:0] PIX_LAST = AW'(N - 1);
    localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] OMIN = -OMAX - 1;

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, DRAIN} state_t;
    state_t state, state_nx;

    logic [MW-1:0]               mac_cnt;
    logic [AW-1:0]               in_pix, pix_addr, rd_addr;
    logic signed [2*DATA_W-1:0]  prod_r;
    logic                        prod_v, prod_last, close_pend;
    logic signed [ACC_W-1:0]     acc;
    logic [OUT_W-1:0]            res_buf [N];

    logic                        take, pair_last, word_done;
    logic signed [ACC_W:0]       v_sum, v_relu;
    logic [OUT_W-1:0]            v_out;
    logic                        v_sat;

    assign take      = in_valid & in_ready;
    assign pair_last = (mac_cnt == MAC_LAST);
    assign word_done = (state == DRAIN) && rlt_ready && (rd_addr == PIX_LAST);

    // close_pend marks the cycle the finished sum sits in acc; it is written out here
    always_comb begin
        v_sum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-OUT_W){bias[OUT_W-1]}}, bias};
        v_relu = ((RELU_EN != 0) && (v_sum < 0)) ? '0 : v_sum;
        v_sat  = 1'b0;
        v_out  = v_relu[OUT_W-1:0];
        if (v_relu > OMAX) begin
            v_out = {1'b0, {(OUT_W-1){1'b1}}};
            v_sat = 1'b1;
        end else if (v_relu < OMIN) begin
            v_out = {1'b1, {(OUT_W-1){1'b0}}};
            v_sat = 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = (state == ACC);
        busy      = (state != IDLE);
        rlt_valid = (state == DRAIN);
        rlt_data  = rlt_valid ? res_buf[rd_addr] : '0;
        rlt_last  = rlt_valid && (rd_addr == PIX_LAST);
        case (state)
            IDLE:  if (start) state_nx = ACC;
            ACC:   if (take && pair_last && in_pix == PIX_LAST) state_nx = FLUSH;
            FLUSH: if (close_pend && pix_addr == PIX_LAST) state_nx = DRAIN;
            DRAIN: if (word_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            state      <= IDLE;
            mac_cnt    <= '0;
            in_pix     <= '0;
            pix_addr   <= '0;
            rd_addr    <= '0;
            prod_r     <= '0;
            prod_v     <= 1'b0;
            prod_last  <= 1'b0;
            close_pend <= 1'b0;
            acc        <= '0;
            frame_done <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= word_done;
            prod_v     <= take;
            prod_last  <= take && pair_last;
            close_pend <= prod_v && prod_last;
            if (take) prod_r <= img_cal * wei_cal;
            if (state == IDLE) begin
                mac_cnt  <= '0;
                in_pix   <= '0;
                pix_addr <= '0;
                rd_addr  <= '0;
                acc      <= '0;
                if (start) sat_flag <= 1'b0;
            end else begin
                if (take) begin
                    mac_cnt <= pair_last ? '0 : mac_cnt + 1'b1;
                    if (pair_last) in_pix <= in_pix + 1'b1;
                end
                // next pixel's first product may land while the previous sum is being closed
                if (prod_v) acc <= (close_pend ? '0 : acc) + ACC_W'(prod_r);
                else if (close_pend) acc <= '0;
                if (close_pend) begin
                    pix_addr <= pix_addr + 1'b1;
                    if (v_sat) sat_flag <= 1'b1;
                end
                if (state == DRAIN && rlt_ready) rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_en) begin
        if (close_pend) res_buf[pix_addr] <= v_out;
    end

endmodule

// File: tb/tb_conv_acc_stream.sv
// Bench for conv_acc_stream: table-driven frames, hand-written reset/stall sequences,
// and random frames scored against an arithmetic reference.
module tb_conv_acc_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, in_valid, rlt_ready, sel;
    logic signed [7:0]  img, wei;
    logic signed [15:0] bias;
    logic        ir0, rv0, rl0, bz0, fd0, sf0, ir1, rv1, rl1, bz1, fd1, sf1;
    logic [15:0] rd0, rd1;
    logic        start0, start1, ir_m, rv_m, rl_m, bz_m, fd_m, sf_m;
    logic [15:0] rd_m;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign ir_m = sel ? ir1 : ir0;
    assign rv_m = sel ? rv1 : rv0;
    assign rl_m = sel ? rl1 : rl0;
    assign bz_m = sel ? bz1 : bz0;
    assign fd_m = sel ? fd1 : fd0;
    assign sf_m = sel ? sf1 : sf0;
    assign rd_m = sel ? rd1 : rd0;

    conv_acc_stream #(.RESULT_W(2), .RESULT_H(2)) d0 (
        .clk_en(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid), .in_ready(ir0),
        .img_cal(img), .wei_cal(wei), .bias(bias), .rlt_valid(rv0), .rlt_ready(rlt_ready),
        .rlt_data(rd0), .rlt_last(rl0), .busy(bz0), .frame_done(fd0), .sat_flag(sf0));

    conv_acc_stream #(.CHANNELS(2), .RESULT_W(2), .RESULT_H(2), .RELU_EN(1)) d1 (
        .clk_en(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(ir1),
        .img_cal(img), .wei_cal(wei), .bias(bias), .rlt_valid(rv1), .rlt_ready(rlt_ready),
        .rlt_data(rd1), .rlt_last(rl1), .busy(bz1), .frame_done(fd1), .sat_flag(sf1));

    int tests = 0, fails = 0;
    int img_a [64], wei_a [64];
    logic [15:0] exp_w [4];
    bit exp_sat;

    typedef struct {
        bit sel; int img; int wei; int bias;
        bit stall; bit inj; bit rgap;
        logic [15:0] exp; bit sat;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference: plain sum of products per pixel, wrapped to 24 bits, then bias/ReLU/clamp
    function automatic void model(input int kc, input bit relu, input int b);
        longint s;
        exp_sat = 1'b0;
        for (int p = 0; p < 4; p++) begin
            s = 0;
            for (int k = 0; k < kc; k++) s += longint'(img_a[p*kc+k] * wei_a[p*kc+k]);
            s = (s <<< 40) >>> 40;
            s += b;
            if (relu && s < 0) s = 0;
            if (s > 32767) begin s = 32767; exp_sat = 1'b1; end
            else if (s < -32768) begin s = -32768; exp_sat = 1'b1; end
            exp_w[p] = 16'(s);
        end
    endfunction

    task automatic run_frame(input int total, input bit stall, input bit inj,
                             input bit rgap, input bit rrdy);
        int idx = 0, nw = 0, fd = 0, stall_c = 0, cyc = 0;
        bit held = 0, fired = 0, done = 0;
        logic [15:0] hd;
        logic hl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", bz_m, 1);
        check("in_ready_after_start", ir_m, 1);
        check("sat_cleared_at_start", sf_m, 0);
        while (!done && cyc < 2000) begin
            if (fd_m) begin
                fd++;
                check("busy_after_done", bz_m, 0);
            end
            start = inj && (cyc == 3 || (rv_m && nw == 2 && !fired));
            if (start && rv_m) fired = 1;
            if (idx < total && !(rgap && $urandom_range(0, 2) == 0)) begin
                in_valid = 1'b1;
                img = 8'(img_a[idx]);
                wei = 8'(wei_a[idx]);
            end else begin
                in_valid = 1'b0;
                img = 8'($urandom);
                wei = 8'($urandom);
            end
            if (stall && nw == 1 && stall_c < 3) begin
                rlt_ready = 1'b0;
                stall_c++;
            end else rlt_ready = rrdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (in_valid && ir_m) idx++;
            if (held) begin
                check("hold_valid", rv_m, 1);
                check("hold_data", rd_m, hd);
                check("hold_last", rl_m, hl);
            end
            held = 0;
            if (rv_m) begin
                if (rlt_ready) begin
                    if (nw < 4) begin
                        check($sformatf("word%0d", nw), rd_m, exp_w[nw]);
                        check($sformatf("last%0d", nw), rl_m, nw == 3);
                        if (nw == 3) check("sat_flag", sf_m, exp_sat);
                    end else check("extra_word", nw, 3);
                    nw++;
                end else begin
                    held = 1; hd = rd_m; hl = rl_m;
                end
            end
            if (nw >= 4 && fd > 0) done = 1;
            cyc++;
            @(negedge clk);
        end
        check("frame_complete", done, 1);
        check("words_delivered", nw, 4);
        if (stall) check("stall_cycles", stall_c, 3);
        start = 1'b0; in_valid = 1'b0; rlt_ready = 1'b1;
        repeat (3) begin
            fd += fd_m;
            @(negedge clk);
        end
        check("frame_done_once", fd, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int kc;
        sel = v.sel;
        kc = v.sel ? 8 : 4;
        bias = 16'(v.bias);
        for (int i = 0; i < 4*kc; i++) begin img_a[i] = v.img; wei_a[i] = v.wei; end
        for (int p = 0; p < 4; p++) exp_w[p] = v.exp;
        exp_sat = v.sat;
        @(negedge clk);
        run_frame(4*kc, v.stall, v.inj, v.rgap, 1'b0);
    endtask

    initial begin
        tbl[0] = '{0, 1, 2, 3, 0, 0, 0, 16'd11, 0};
        tbl[1] = '{0, -1, 5, 0, 0, 0, 0, 16'hFFEC, 0};
        tbl[2] = '{1, -1, 5, 0, 0, 0, 0, 16'h0000, 0};
        tbl[3] = '{1, 127, 127, 0, 0, 0, 0, 16'h7FFF, 1};
        tbl[4] = '{1, 1, 2, 3, 0, 0, 0, 16'd19, 0};
        tbl[5] = '{0, 1, 2, 3, 1, 0, 1, 16'd11, 0};
        tbl[6] = '{0, 1, 2, 3, 0, 1, 0, 16'd11, 0};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; rlt_ready = 1'b1; sel = 1'b0;
        img = '0; wei = '0; bias = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("rst_in_ready", ir_m, 0);
            check("rst_rlt_valid", rv_m, 0);
            check("rst_rlt_data", rd_m, 0);
            check("rst_rlt_last", rl_m, 0);
            check("rst_busy", bz_m, 0);
            check("rst_frame_done", fd_m, 0);
            check("rst_sat_flag", sf_m, 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Reset after 9 accepted pairs, then a clean frame
        begin
            int idx = 0, cyc = 0;
            sel = 1'b0; bias = 16'sd3;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (idx < 9 && cyc < 100) begin
                in_valid = 1'b1; img = 8'sd1; wei = 8'sd2;
                if (ir_m) idx++;
                cyc++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            check("midrst_busy", bz_m, 0);
            check("midrst_in_ready", ir_m, 0);
            check("midrst_rlt_valid", rv_m, 0);
            rst_n = 1'b1;
            run_vec(tbl[0]);
        end

        // Random frames against the reference model
        for (int f = 0; f < 12; f++) begin
            int kc, b;
            sel = 1'($urandom_range(0, 1));
            kc = sel ? 8 : 4;
            for (int i = 0; i < 4*kc; i++) begin
                img_a[i] = int'($urandom_range(0, 255)) - 128;
                wei_a[i] = int'($urandom_range(0, 255)) - 128;
            end
            b = int'($urandom_range(0, 65535)) - 32768;
            bias = 16'(b);
            model(kc, sel, b);
            @(negedge clk);
            run_frame(4*kc, 1'b0, 1'b0, 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
